// File: rtl/hms_clock_core.sv
// ============================================================================
// hms_clock_core : hours:minutes:seconds time-of-day core with button set mode
// Revision 1.0
// ============================================================================
`default_nettype none

module hms_clock_core #(
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_six_dp,
  output logic       o_carry_day
);

  localparam logic [1:0] c_clock    = 2'd0;
  localparam logic [1:0] c_set_sec  = 2'd1;
  localparam logic [1:0] c_set_min  = 2'd2;
  localparam logic [1:0] c_set_hour = 2'd3;

  localparam logic [5:0] c_sec_max  = 6'(SEC_MAX);
  localparam logic [5:0] c_min_max  = 6'(MIN_MAX);
  localparam logic [4:0] c_hour_max = 5'(HOUR_MAX);

  logic [5:0] sec_q,   sec_d;
  logic [5:0] min_q,   min_d;
  logic [4:0] hour_q,  hour_d;
  logic [1:0] mode_q,  mode_d;
  logic [5:0] dp_q,    dp_d;
  logic       carry_q, carry_d;

  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hour_wrap;
  logic [5:0] w_sec_inc;
  logic [5:0] w_min_inc;
  logic [4:0] w_hour_inc;

  // ">=" rather than "==" so an out-of-range value still wraps back to 0
  assign w_sec_wrap  = (sec_q  >= c_sec_max);
  assign w_min_wrap  = (min_q  >= c_min_max);
  assign w_hour_wrap = (hour_q >= c_hour_max);
  assign w_sec_inc   = w_sec_wrap  ? 6'd0 : sec_q  + 6'd1;
  assign w_min_inc   = w_min_wrap  ? 6'd0 : min_q  + 6'd1;
  assign w_hour_inc  = w_hour_wrap ? 5'd0 : hour_q + 5'd1;

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    mode_d  = mode_q;
    carry_d = 1'b0;

    if (mode_q == c_clock) begin
      if (i_tick) begin
        sec_d = w_sec_inc;
        if (w_sec_wrap) begin
          min_d = w_min_inc;
          if (w_min_wrap) begin
            hour_d  = w_hour_inc;
            carry_d = w_hour_wrap;
          end
        end
      end
      if (i_mode) begin
        mode_d = c_set_sec;
      end
    end else if (i_mode) begin
      mode_d = mode_q + 2'd1;
    end else if (i_inc) begin
      case (mode_q)
        c_set_sec:  sec_d  = w_sec_inc;
        c_set_min:  min_d  = w_min_inc;
        c_set_hour: hour_d = w_hour_inc;
        default:    sec_d  = sec_q;
      endcase
    end

    case (mode_d)
      c_set_sec:  dp_d = 6'b000011;
      c_set_min:  dp_d = 6'b001100;
      c_set_hour: dp_d = 6'b110000;
      default:    dp_d = 6'b000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      mode_q  <= c_clock;
      dp_q    <= 6'd0;
      carry_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      mode_q  <= mode_d;
      dp_q    <= dp_d;
      carry_q <= carry_d;
    end
  end

  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hour      = hour_q;
  assign o_mode      = mode_q;
  assign o_six_dp    = dp_q;
  assign o_carry_day = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_hms_clock_core.sv
// ============================================================================
// tb_hms_clock_core : randomized and directed checks against a time-of-day model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hms_clock_core;

  logic       clk;
  logic       rst;
  logic       i_tick;
  logic       i_mode;
  logic       i_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic [5:0] o_six_dp;
  logic       o_carry_day;

  int total;
  int bad;

  // reference state
  int m_sec, m_min, m_hour, m_mode, m_carry;

  hms_clock_core dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_mode      (i_mode),
    .i_inc       (i_inc),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_mode      (o_mode),
    .o_six_dp    (o_six_dp),
    .o_carry_day (o_carry_day)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dp_of(input int md);
    return (md == 0) ? 0 : (3 << (2 * (md - 1)));
  endfunction

  // time of day as seconds-since-midnight; set mode edits one field modulo its range
  task automatic model_edge(input bit t, input bit m, input bit n, input bit r);
    int tod;
    if (r) begin
      m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_carry = 0;
      return;
    end
    m_carry = 0;
    if (m_mode == 0) begin
      if (t) begin
        tod = m_hour * 3600 + m_min * 60 + m_sec + 1;
        if (tod == 86400) begin
          tod = 0;
          m_carry = 1;
        end
        m_hour = tod / 3600;
        m_min  = (tod / 60) % 60;
        m_sec  = tod % 60;
      end
      if (m) m_mode = 1;
    end else if (m) begin
      m_mode = (m_mode + 1) % 4;
    end else if (n) begin
      case (m_mode)
        1: m_sec  = (m_sec + 1) % 60;
        2: m_min  = (m_min + 1) % 60;
        default: m_hour = (m_hour + 1) % 24;
      endcase
    end
  endtask

  task automatic compare_all();
    check("sec",   int'(o_sec),       m_sec);
    check("min",   int'(o_min),       m_min);
    check("hour",  int'(o_hour),      m_hour);
    check("mode",  int'(o_mode),      m_mode);
    check("dp",    int'(o_six_dp),    dp_of(m_mode));
    check("carry", int'(o_carry_day), m_carry);
  endtask

  task automatic step(input bit t, input bit m, input bit n, input bit r);
    i_tick = t; i_mode = m; i_inc = n; rst = r;
    @(posedge clk);
    model_edge(t, m, n, r);
    #1;
    compare_all();
    i_tick = 1'b0; i_mode = 1'b0; i_inc = 1'b0; rst = 1'b0;
  endtask

  task automatic incs(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // from CLOCK at 00:00:00, load h:m:s and return to CLOCK
  task automatic load_time(input int h, input int mi, input int s);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(s);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(mi);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(h);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0; m_carry = 0;
    rst = 1'b1; i_tick = 1'b0; i_mode = 1'b0; i_inc = 1'b0;

    // reset dominates simultaneous pulses
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_sec",  int'(o_sec), 0);
    check("rst_mode", int'(o_mode), 0);
    check("rst_dp",   int'(o_six_dp), 0);

    // seconds to minutes carry
    load_time(0, 0, 58);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("s59", int'(o_sec), 59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("roll_sec", int'(o_sec), 0);
    check("roll_min", int'(o_min), 1);
    check("roll_carry", int'(o_carry_day), 0);

    // day wrap
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_time(23, 59, 59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("day_hour", int'(o_hour), 0);
    check("day_carry", int'(o_carry_day), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("day_carry_drop", int'(o_carry_day), 0);

    // mode cycle and dp
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dp_sec", int'(o_six_dp), 6'b000011);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dp_min", int'(o_six_dp), 6'b001100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dp_hour", int'(o_six_dp), 6'b110000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dp_clock", int'(o_six_dp), 0);

    // minute wrap in set mode without carry, ticks frozen
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(59);
    incs(1);
    check("setmin_wrap", int'(o_min), 0);
    check("setmin_hour", int'(o_hour), 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("frozen_sec", int'(o_sec), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // mode beats inc; reset out of SET_HOUR
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    incs(3);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("mode_prio", int'(o_mode), 2);
    check("mode_prio_sec", int'(o_sec), 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_set_mode", int'(o_mode), 0);

    // tick + mode in CLOCK on the same edge
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_mode_sec", int'(o_sec), 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 6),
           1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 999) < 3));
    end

    // long run in CLOCK to exercise hour and day wraps
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load_time(23, 58, 30);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
